sdram_rr_arbiter: RTL and testbench
===================================

Name: sdram_rr_arbiter

Overview:
Shares the single 16-bit Avalon-MM SDRAM master port among N_REQ datapath engines, such as the image copier and layer engines, using round-robin arbitration. The arbiter holds at most one transaction in flight and forwards read data, or a timeout error, back to the requester that was granted. It sits between the engines and the SDRAM controller port and owns chipselect, byteenable, read_n and write_n.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, Avalon byte address width
DATA_W, 16, data width
RD_TIMEOUT, 255, maximum cycles in RD_WAIT before an error response is forced

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-requester request; held high with stable fields until req_ack
req_write  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_ack  out  N_REQ  one-cycle pulse: request accepted by SDRAM
rsp_valid  out  N_REQ  one-cycle pulse: read response for requester i
rsp_data  out  DATA_W  read data, valid with any rsp_valid bit
rsp_err  out  1  valid with rsp_valid; 1 = read timed out
chipselect  out  1  tied 1
byteenable  out  2  tied 2'b11
read_n  out  1  active-low Avalon read
write_n  out  1  active-low Avalon write
address  out  ADDR_W  Avalon address
writedata  out  DATA_W  Avalon write data
waitrequest  in  1  Avalon stall
readdatavalid  in  1  Avalon read data valid
readdata  in  DATA_W  Avalon read data
grant_id  out  3  index of the current or last granted requester (debug/hex LED)
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset behaviour:
  - All outputs are registered, except the tied chipselect and byteenable.
  - On reset: read_n=1, write_n=1, address=0, writedata=0, req_ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, grant_id=0, busy=0, rr_ptr=0, state=IDLE, timer=0.
  - Reset asserted mid-transaction aborts it at the next edge. No ack or response is ever issued for an aborted transaction.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Eligible requesters are req_valid & ~req_ack. The mask prevents re-granting a request during its own ack cycle.
  - If any requester is eligible, pick the first eligible index at or after rr_ptr (with wrap-around). Latch its index, address, wdata and write bit. Set read_n or write_n low, set busy=1, go to ISSUE.
  - Latency: req_valid seen at edge k gives the Avalon strobe asserted from cycle k+1.
- ISSUE:
  - Strobe and fields are held stable while waitrequest=1, with no limit.
  - At the edge where waitrequest=0, the transaction is accepted:
    - strobe returns high and req_ack[g]=1 for exactly one cycle;
    - rr_ptr becomes (g+1) mod N_REQ.
  - Write: go to IDLE, busy=0.
  - Read: go to RD_WAIT, timer=0.
- RD_WAIT:
  - On readdatavalid=1: rsp_valid[g]=1, rsp_data=readdata, rsp_err=0, then go to IDLE.
  - Otherwise the timer increments. When timer reaches RD_TIMEOUT: rsp_valid[g]=1, rsp_data=0, rsp_err=1, then go to IDLE.
  - If readdatavalid and timeout occur on the same edge, the data response wins.
- readdatavalid outside RD_WAIT is ignored.
- A requester may keep req_valid high after its ack and present new fields. It re-enters arbitration behind the other requesters because rr_ptr has advanced.
- At most one strobe is low at any time. read_n and write_n are never both low.
- Indices are taken mod N_REQ. Addresses pass through without modification; requesters increment addresses by 2 per 16-bit word.

Decomposition:
- Shared package sdram_pkg holds:
  - the state enum (IDLE/ISSUE/RD_WAIT);
  - DATA_W and ADDR_W defaults;
  - buffer base addresses IMG_BASE=600_000 and LAYER1_BASE=650_000;
  - WORDS_PER_IMG=784.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the eligible vector and rr_ptr; outputs are the any_valid flag and the index.

Test Plan:
- Single read: requester 1 reads 600_000; waitrequest high for 2 cycles; readdatavalid with 16'hABCD 3 cycles after accept -> read_n low for 3 cycles, req_ack[1] one pulse, rsp_valid[1] with rsp_data=16'hABCD, rsp_err=0.
- Single write: requester 0 writes 16'h1234 to 650_000 with waitrequest=0 -> write_n low for exactly 1 cycle, address=650_000, writedata=16'h1234, req_ack[0] pulse, busy=0 the next cycle.
- Contention: all 4 requesters hold continuous writes for 8 grants -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice in a row.
- Back-to-back: requester 2 alone keeps req_valid high with new fields after each ack -> each request is granted exactly once and no duplicate write is issued in the ack cycle.
- Timeout: read with readdatavalid never asserted -> after 255 cycles in RD_WAIT, rsp_valid[g]=1, rsp_err=1, rsp_data=0; the next request is then serviced normally.
- Reset in RD_WAIT, then a late readdatavalid -> all outputs at reset values, no rsp_valid pulse, rr_ptr=0, next grant goes to requester 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: controller FSM states, bus widths and
// frame-buffer layout constants used by the datapath engines.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } state_e;

    localparam int unsigned SDRAM_ADDR_W  = 32;
    localparam int unsigned SDRAM_DATA_W  = 16;

    localparam int unsigned IMG_BASE      = 600_000;
    localparam int unsigned LAYER1_BASE   = 650_000;
    localparam int unsigned WORDS_PER_IMG = 784;

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// Requester-side handshake plus Avalon-MM master bus of the SDRAM arbiter.
// slave = arbiter view, master = engines/SDRAM controller view.
interface sdram_rr_arbiter_if
    import sdram_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = SDRAM_ADDR_W,
    parameter int unsigned DATA_W = SDRAM_DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;

    logic                    chipselect;
    logic [1:0]              byteenable;
    logic                    read_n;
    logic                    write_n;
    logic [ADDR_W-1:0]       address;
    logic [DATA_W-1:0]       writedata;
    logic                    waitrequest;
    logic                    readdatavalid;
    logic [DATA_W-1:0]       readdata;

    logic [2:0]              grant_id;
    logic                    busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  waitrequest, readdatavalid, readdata,
        output req_ack, rsp_valid, rsp_data, rsp_err,
        output chipselect, byteenable, read_n, write_n, address, writedata,
        output grant_id, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output waitrequest, readdatavalid, readdata,
        input  req_ack, rsp_valid, rsp_data, rsp_err,
        input  chipselect, byteenable, read_n, write_n, address, writedata,
        input  grant_id, busy
    );

endinterface

// File: rtl/sdram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i,
// wrapping around N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int unsigned j;
        j     = '0;
        any_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr_i) + i) % N_REQ;
            if (!any_o && elig_i[j[IDX_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master port among N_REQ
// engines; one transaction in flight, read data or timeout routed back.
module sdram_rr_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
    parameter int unsigned DATA_W     = SDRAM_DATA_W,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    sdram_rr_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic                wr_q, wr_d;
    logic                read_n_q, read_n_d;
    logic                write_n_q, write_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [N_REQ-1:0]    elig;
    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    // Masking with the ack keeps a still-high req_valid from being re-granted
    // in the very cycle its previous request is acknowledged.
    assign elig = bus.req_valid & ~ack_q;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        read_n_d    = read_n_q;
        write_n_d   = write_n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        timer_d     = timer_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d     = pick_idx;
                    wr_d      = bus.req_write[pick_idx];
                    addr_d    = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d   = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
                    read_n_d  = bus.req_write[pick_idx];
                    write_n_d = ~bus.req_write[pick_idx];
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.waitrequest) begin
                    read_n_d     = 1'b1;
                    write_n_d    = 1'b1;
                    ack_d[gnt_q] = 1'b1;
                    ptr_d        = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    if (wr_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (bus.readdatavalid) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_data_d         = bus.readdata;
                    rsp_err_d          = 1'b0;
                    busy_d             = 1'b0;
                    state_d            = IDLE;
                end else if (timer_d == TMR_W'(RD_TIMEOUT)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                    busy_d             = 1'b0;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            wr_q        <= 1'b0;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            read_n_q    <= read_n_d;
            write_n_q   <= write_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.chipselect = 1'b1;
    assign bus.byteenable = 2'b11;
    assign bus.read_n     = read_n_q;
    assign bus.write_n    = write_n_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign bus.req_ack    = ack_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.grant_id   = 3'(gnt_q);
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_sdram_rr_arbiter;
    import sdram_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_rr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Model state: pending request per requester, round-robin pointer and
    // the requester whose write ack is currently visible (-1 if none).
    bit          mv[N];
    bit          mw[N];
    logic [31:0] ma[N];
    logic [15:0] md[N];
    int          ptr = 0;
    int          last_ack = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = mv[i];
            bus.req_write[i]            = mw[i];
            bus.req_addr[i*AW +: AW]    = ma[i];
            bus.req_wdata[i*DW +: DW]   = md[i];
        end
    endtask

    function automatic int exp_winner();
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - ptr + N) % N;
            if (mv[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic new_fields(input int i, input bit wr_only);
        mv[i] = 1'b1;
        mw[i] = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
        ma[i] = IMG_BASE + 2 * $urandom_range(0, WORDS_PER_IMG - 1);
        md[i] = 16'($urandom);
    endtask

    task automatic check_reset_outputs();
        chk("rst_read_n",    64'(bus.read_n),     64'd1);
        chk("rst_write_n",   64'(bus.write_n),    64'd1);
        chk("rst_address",   64'(bus.address),    64'd0);
        chk("rst_writedata", 64'(bus.writedata),  64'd0);
        chk("rst_req_ack",   64'(bus.req_ack),    64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
        chk("rst_rsp_data",  64'(bus.rsp_data),   64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),    64'd0);
        chk("rst_grant_id",  64'(bus.grant_id),   64'd0);
        chk("rst_busy",      64'(bus.busy),       64'd0);
        chk("chipselect",    64'(bus.chipselect), 64'd1);
        chk("byteenable",    64'(bus.byteenable), 64'd3);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        drive_reqs();
        bus.waitrequest   = 1'b1;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        step();
        step();
        check_reset_outputs();
        reset_n  = 1'b1;
        ptr      = 0;
        last_ack = -1;
    endtask

    // One full transaction. lat = 0 means the read never gets readdatavalid.
    // keep: 0 drop request after ack, 1 new write fields, 2 random refresh.
    task automatic do_txn(input int wcyc, input int lat, input logic [15:0] rdat,
                          input int keep, output int g);
        int  el, cnt;
        bit  others, was_wr;
        logic [31:0] a;
        g = exp_winner();
        others = 1'b0;
        for (int i = 0; i < N; i++) if (mv[i] && i != last_ack) others = 1'b1;
        el = (last_ack >= 0 && !others) ? 2 : 1;
        was_wr = mw[g];
        a = ma[g];
        drive_reqs();
        bus.waitrequest   = 1'b1;
        bus.readdatavalid = 1'b0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (bus.read_n && bus.write_n && cnt < 8);
        chk("grant_latency", 64'(cnt), 64'(el));
        chk("grant_id", 64'(bus.grant_id), 64'(g));
        chk("strobes", {62'd0, bus.read_n, bus.write_n}, {62'd0, was_wr, !was_wr});
        chk("address", 64'(bus.address), 64'(a));
        if (was_wr) chk("writedata", 64'(bus.writedata), 64'(md[g]));
        chk("busy_issue", 64'(bus.busy), 64'd1);
        for (int k = 0; k < wcyc; k++) begin
            step();
            chk("hold_strobes", {62'd0, bus.read_n, bus.write_n}, {62'd0, was_wr, !was_wr});
            chk("hold_address", 64'(bus.address), 64'(a));
            chk("hold_no_ack", 64'(bus.req_ack), 64'd0);
        end
        bus.waitrequest = 1'b0;
        step();
        bus.waitrequest = 1'b1;
        chk("ack_pulse", 64'(bus.req_ack), 64'(1 << g));
        chk("strobes_release", {62'd0, bus.read_n, bus.write_n}, 64'd3);
        ptr = (g + 1) % N;
        if (keep == 0) mv[g] = 1'b0;
        else if (keep == 1) new_fields(g, 1'b1);
        else begin
            if ($urandom_range(0, 2) == 0) mv[g] = 1'b0;
            else new_fields(g, 1'b0);
            for (int i = 0; i < N; i++)
                if (!mv[i] && $urandom_range(0, 1) == 1) new_fields(i, 1'b0);
        end
        drive_reqs();
        if (was_wr) begin
            chk("busy_after_write", 64'(bus.busy), 64'd0);
            last_ack = g;
        end else begin
            last_ack = -1;
            chk("busy_rd_wait", 64'(bus.busy), 64'd1);
            if (lat == 0) begin
                for (int k = 1; k < TO; k++) begin
                    step();
                    chk("no_early_timeout", 64'(bus.rsp_valid), 64'd0);
                end
                step();
                chk("timeout_valid", 64'(bus.rsp_valid), 64'(1 << g));
                chk("timeout_err", 64'(bus.rsp_err), 64'd1);
                chk("timeout_data", 64'(bus.rsp_data), 64'd0);
            end else begin
                for (int k = 1; k < lat; k++) begin
                    bus.readdata = 16'($urandom);
                    step();
                    chk("rsp_wait", 64'(bus.rsp_valid), 64'd0);
                end
                bus.readdatavalid = 1'b1;
                bus.readdata      = rdat;
                step();
                bus.readdatavalid = 1'b0;
                bus.readdata      = 16'($urandom);
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << g));
                chk("rsp_data", 64'(bus.rsp_data), 64'(rdat));
                chk("rsp_err", 64'(bus.rsp_err), 64'd0);
            end
            chk("busy_after_rsp", 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int g, prev;
        bus.waitrequest   = 1'b1;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = '0;
        end
        do_reset();

        // Single read with two stall cycles and data three cycles after accept
        mv[1] = 1'b1; mw[1] = 1'b0; ma[1] = IMG_BASE; md[1] = '0;
        do_txn(2, 3, 16'hABCD, 0, g);
        chk("single_read_gid", 64'(g), 64'd1);

        // Single write, no stall
        mv[0] = 1'b1; mw[0] = 1'b1; ma[0] = LAYER1_BASE; md[0] = 16'h1234;
        do_txn(0, 0, '0, 0, g);
        chk("single_write_gid", 64'(g), 64'd0);

        // Contention: four continuous writers
        do_reset();
        for (int i = 0; i < N; i++) new_fields(i, 1'b1);
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            do_txn($urandom_range(0, 2), 0, '0, 1, g);
            chk("contention_order", 64'(g), 64'(k % N));
            chk("no_regrant", 64'(g == prev), 64'd0);
            prev = g;
        end
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        drive_reqs();
        step();
        last_ack = -1;

        // Back-to-back: requester 2 alone keeps its request up
        new_fields(2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            do_txn($urandom_range(0, 1), 0, '0, 1, g);
            chk("b2b_gid", 64'(g), 64'd2);
        end
        mv[2] = 1'b0;
        drive_reqs();
        step();
        last_ack = -1;

        // Read timeout, then a normal read; then data exactly at the limit
        new_fields(1, 1'b0); mw[1] = 1'b0;
        do_txn(1, 0, '0, 0, g);
        new_fields(3, 1'b0); mw[3] = 1'b0;
        do_txn(0, 2, 16'h5A5A, 0, g);
        new_fields(0, 1'b0); mw[0] = 1'b0;
        do_txn(0, TO, 16'hC3C3, 0, g);

        // Reset during RD_WAIT followed by a stray readdatavalid
        do_reset();
        new_fields(1, 1'b0); mw[1] = 1'b0;
        drive_reqs();
        bus.waitrequest = 1'b0;
        step();
        step();
        bus.waitrequest = 1'b1;
        chk("abort_ack", 64'(bus.req_ack), 64'd2);
        mv[1] = 1'b0;
        drive_reqs();
        step();
        step();
        reset_n = 1'b0;
        step();
        check_reset_outputs();
        reset_n = 1'b1;
        ptr = 0;
        last_ack = -1;
        bus.readdatavalid = 1'b1;
        bus.readdata      = 16'hBEEF;
        step();
        bus.readdatavalid = 1'b0;
        chk("late_rdv_ignored", 64'(bus.rsp_valid), 64'd0);
        chk("late_rdv_busy", 64'(bus.busy), 64'd0);
        step();
        chk("late_rdv_ignored2", 64'(bus.rsp_valid), 64'd0);
        new_fields(0, 1'b1);
        new_fields(2, 1'b1);
        do_txn(0, 0, '0, 0, g);
        chk("post_reset_gid", 64'(g), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= mv[i];
            if (!any) new_fields($urandom_range(0, N - 1), 1'b0);
            do_txn($urandom_range(0, 3), $urandom_range(1, 6), 16'($urandom), 2, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
